// File: rtl/paleta_cor.sv
// paleta_cor -- programmable colour-palette unit.
//
// Maps an IDX_W-bit colour index to an RGB triple read from a writable
// palette register file of 2^IDX_W entries. Each entry also holds a blink
// flag. A free-running blink divider flashes flagged entries to black while
// blink_en is high.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_idx            lookup request, sampled every cycle
//   wr_en, wr_addr              palette write strobe and target entry
//   wr_red/green/blue, wr_blink new contents for the written entry
//   blink_en                    global blink enable
//   out_valid, red/green/blue   registered lookup result, 2 register stages
//
// Flow control: there is no handshake. in_valid is a plain qualifier that is
// sampled on every rising edge, and out_valid qualifies red/green/blue. The
// unit never stalls and applies no backpressure. Writes run beside the lookup
// pipeline and never disturb it.
module paleta_cor #(
  parameter int IDX_W     = 4,
  parameter int CH_W      = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [CH_W-1:0]   wr_red,
  input  logic [CH_W-1:0]   wr_green,
  input  logic [CH_W-1:0]   wr_blue,
  input  logic              wr_blink,
  input  logic              blink_en,
  output logic              out_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  // Palette storage
  logic [CH_W-1:0] pal_r  [DEPTH];
  logic [CH_W-1:0] pal_g  [DEPTH];
  logic [CH_W-1:0] pal_b  [DEPTH];
  logic            pal_bl [DEPTH];

  // Stage 1 registers
  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;

  // Blink divider
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  logic             blank;

  // Palette write port. The reset clears every entry, so a write that lands
  // in the same cycle as a reset assertion is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pal_r[i]  <= '0;
        pal_g[i]  <= '0;
        pal_b[i]  <= '0;
        pal_bl[i] <= 1'b0;
      end
    end else if (wr_en) begin
      pal_r[wr_addr]  <= wr_red;
      pal_g[wr_addr]  <= wr_green;
      pal_b[wr_addr]  <= wr_blue;
      pal_bl[wr_addr] <= wr_blink;
    end
  end

  // Stage 1: capture the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_idx   <= in_idx;
    end
  end

  // The divider runs even when blink_en is low, so the blink phase keeps a
  // steady rhythm whenever blinking is turned on. Phase 0 is the visible half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Stage 2 reads the palette as it stands before this edge. A write made on
  // the previous edge is therefore already visible. blink_phase is also the
  // pre-edge value, so a toggle on this edge does not affect this sample.
  always_comb begin
    blank = !s1_valid || (blink_en && blink_phase && pal_bl[s1_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      out_valid <= s1_valid;
      red       <= blank ? '0 : pal_r[s1_idx];
      green     <= blank ? '0 : pal_g[s1_idx];
      blue      <= blank ? '0 : pal_b[s1_idx];
    end
  end

endmodule
